i2s_tx: RTL
===========

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter clkspeed, default 27000000, system clock frequency in Hz.
REQ-002 SHALL have parameter bclkfreq, default 1536000, target bit-clock frequency in Hz (48 kHz x 32 bits).
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port inSound, input, 15, unsigned offset-binary mono sample (low-pass filter output format).
REQ-006 SHALL have port inValid, input, 1, inSound is valid this cycle.
REQ-007 SHALL have port inReady, output, 1, holding register is empty and accepts a sample.
REQ-008 SHALL have port i2s_bclk, output, 1, serial bit clock.
REQ-009 SHALL have port i2s_lrck, output, 1, word select: 0 = left slot, 1 = right slot.
REQ-010 SHALL have port i2s_sdata, output, 1, serial data, MSB first.

Function
REQ-011 SHALL define HALF = clkspeed/(2*bclkfreq), using truncating integer division and clamped to a minimum of 1 (default: 8).
REQ-012 SHALL count the prescaler from HALF-1 down to 0, then reload HALF-1 and toggle i2s_bclk on that same cycle ("half-tick").
REQ-013 SHALL, on a half-tick that drives i2s_bclk 1->0 (falling edge), advance the 5-bit bit counter bitcnt modulo 32; bitcnt 31->0 wraps.
REQ-014 SHALL accept a sample when inValid && inReady, storing it in a one-entry holding register; inReady deasserts on the following cycle.
REQ-015 SHALL convert each sample to 16-bit two's complement as {~inSound[14], inSound[13:0], 1'b0}; example: 15'h4000 -> 16'h0000, 15'h7FFF -> 16'h7FFE, 15'h0000 -> 16'h8000.
REQ-016 SHALL, on the falling edge where bitcnt becomes 0, load the 32-bit frame word F = {S16, S16} (mono duplicated into left and right) from the holding register and set inReady=1.
REQ-017 SHALL, if the holding register is empty at frame load, reuse the previous S16 (underrun repeats the last sample with no glitch); after reset, the value reused is 16'h0000.
REQ-018 SHALL give a sample accepted on the same cycle as a frame load to the next frame, not the current one; the holding register is written and inReady goes to 0.
REQ-019 SHALL update i2s_lrck = bitcnt[4] on every falling edge, so that i2s_lrck and i2s_sdata change only on falling edges of i2s_bclk.
REQ-020 SHALL, in standard I2S mode, drive i2s_sdata at bitcnt=0 with the LSB of the previous F, and for bitcnt=k>0 with F[32-k] (one-bclk MSB delay after the lrck edge).
REQ-021 SHALL hold inValid/inSound changes while inReady=0 as having no effect.

Reset
REQ-022 SHALL, while reset=1, asynchronously clear: i2s_bclk=0, i2s_lrck=0, i2s_sdata=0, bitcnt=31, prescaler=HALF-1, holding register empty, F=0, last S16=0, inReady=1.
REQ-023 SHALL, after deassertion, make the first falling edge wrap bitcnt to 0 and load a frame; reset asserted mid-frame aborts the frame immediately with no partial-word completion.

Configuration
REQ-024 SHALL, with macro I2S_TX_LEFT_JUSTIFIED_EN defined, use left-justified format: i2s_sdata = F[31-bitcnt] (MSB coincides with the lrck edge); i2s_lrck polarity is unchanged.
REQ-025 SHALL, with I2S_TX_LEFT_JUSTIFIED_EN undefined, use the standard I2S one-bit-delayed format of REQ-020.

Verification
REQ-026 SHALL verify: default parameters, reset released -> i2s_bclk period 16 clk; lrck period 512 clk; 50% duty on both.
REQ-027 SHALL verify: push 15'h7FFF before the first frame -> both slots serialise 16'h7FFE (I2S: MSB on second bclk after the lrck edge).
REQ-028 SHALL verify: push 15'h0000, then no further samples for 3 frames -> every slot carries 16'h8000; inReady stays 1.
REQ-029 SHALL verify: inValid held high continuously -> exactly one sample accepted per 32-bclk frame; inReady pulses high from each frame load until the next accept.
REQ-030 SHALL verify: reset asserted at bitcnt=10 of a 16'h7FFE frame -> all outputs 0 within the same cycle; after release, output restarts with 16'h0000 frames until a new sample is accepted.
REQ-031 SHALL verify: with I2S_TX_LEFT_JUSTIFIED_EN defined, push 15'h4001 -> slot data 16'h0002 with MSB aligned to the lrck edge.

Source files
------------

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: sample handshake and serial audio pins of the i2s_tx block.
//   inSound   [14:0] offset-binary mono sample from the producer
//   inValid          inSound is valid this cycle
//   inReady          transmitter holding register is empty
//   i2s_bclk         serial bit clock
//   i2s_lrck         word select (0 = left slot, 1 = right slot)
//   i2s_sdata        serial data, MSB first
// Modports: master = sample producer / pin observer, slave = transmitter.
interface i2s_tx_if;
    logic [14:0] inSound;
    logic        inValid;
    logic        inReady;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_sdata;

    modport master (
        output inSound,
        output inValid,
        input  inReady,
        input  i2s_bclk,
        input  i2s_lrck,
        input  i2s_sdata
    );

    modport slave (
        input  inSound,
        input  inValid,
        output inReady,
        output i2s_bclk,
        output i2s_lrck,
        output i2s_sdata
    );
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: mono-to-stereo I2S transmitter.
// Takes 15-bit offset-binary samples through a one-entry holding register,
// converts them to 16-bit two's complement and sends each one in both the
// left and right slot of a 32-bit frame. Bit clock is derived from clk by a
// prescaler of HALF = clkspeed/(2*bclkfreq) cycles per bclk phase.
// Ports:
//   clk    system clock, all logic on its rising edge
//   reset  asynchronous active-high reset
//   bus    i2s_tx_if.slave (inSound/inValid/inReady handshake, I2S pins)
// Build option: define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing
// (MSB coincides with the lrck edge); default is standard I2S with the MSB
// one bclk after the lrck edge.
module i2s_tx #(
    parameter int clkspeed = 27000000,
    parameter int bclkfreq = 1536000
) (
    input  logic    clk,
    input  logic    reset,
    i2s_tx_if.slave bus
);
    localparam int HALF_RAW = clkspeed / (2 * bclkfreq);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int PW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(HALF - 1);
    localparam logic [PW-1:0] PRESC_ONE    = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO   = PW'(0);

    // Offset-binary to two's complement: flip the top bit, pad one LSB.
    function automatic logic [15:0] to_s16(input logic [14:0] s);
        return {~s[14], s[13:0], 1'b0};
    endfunction

    logic          bclk_q,   bclk_d;
    logic          lrck_q,   lrck_d;
    logic          sdata_q,  sdata_d;
    logic          ready_q,  ready_d;
    logic [4:0]    bitcnt_q, bitcnt_d;
    logic [PW-1:0] presc_q,  presc_d;
    logic [15:0]   hold_q,   hold_d;
    logic [31:0]   frame_q,  frame_d;
    logic [15:0]   last_q,   last_d;

    logic          half_tick_s;
    logic          falling_s;
    logic          frame_load_s;
    logic          accept_s;
    logic [15:0]   word_s;
    logic [4:0]    idx_s;

    // State registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_q   <= 1'b0;
            lrck_q   <= 1'b0;
            sdata_q  <= 1'b0;
            ready_q  <= 1'b1;
            bitcnt_q <= 5'd31;
            presc_q  <= PRESC_RELOAD;
            hold_q   <= 16'h0000;
            frame_q  <= 32'h0000_0000;
            last_q   <= 16'h0000;
        end else begin
            bclk_q   <= bclk_d;
            lrck_q   <= lrck_d;
            sdata_q  <= sdata_d;
            ready_q  <= ready_d;
            bitcnt_q <= bitcnt_d;
            presc_q  <= presc_d;
            hold_q   <= hold_d;
            frame_q  <= frame_d;
            last_q   <= last_d;
        end
    end

    // Prescaler, bit counter, frame load, serialiser and sample handshake.
    always_comb begin
        bclk_d   = bclk_q;
        lrck_d   = lrck_q;
        sdata_d  = sdata_q;
        ready_d  = ready_q;
        bitcnt_d = bitcnt_q;
        presc_d  = presc_q;
        hold_d   = hold_q;
        frame_d  = frame_q;
        last_d   = last_q;
        word_s   = last_q;
        idx_s    = 5'd0;

        half_tick_s  = (presc_q == PRESC_ZERO);
        falling_s    = half_tick_s & bclk_q;
        frame_load_s = falling_s & (bitcnt_q == 5'd31);
        accept_s     = bus.inValid & ready_q;

        if (half_tick_s) begin
            presc_d = PRESC_RELOAD;
            bclk_d  = ~bclk_q;
        end else begin
            presc_d = presc_q - PRESC_ONE;
        end

        if (falling_s) begin
            bitcnt_d = bitcnt_q + 5'd1;
            lrck_d   = bitcnt_d[4];

            // An empty holding register repeats the last word (underrun).
            if (frame_load_s) begin
                if (ready_q) begin
                    word_s = last_q;
                end else begin
                    word_s = hold_q;
                end
                frame_d = {word_s, word_s};
                last_d  = word_s;
                ready_d = 1'b1;
            end else begin
                word_s = last_q;
            end

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
            idx_s   = 5'd31 - bitcnt_d;
            sdata_d = frame_d[idx_s];
`else
            // Slot 0 still carries the previous frame's LSB; bit k>0 is F[32-k].
            idx_s = 5'd0 - bitcnt_d;
            if (bitcnt_d == 5'd0) begin
                sdata_d = frame_q[0];
            end else begin
                sdata_d = frame_d[idx_s];
            end
`endif
        end else begin
            bitcnt_d = bitcnt_q;
        end

        // Accept after the frame-load update so a same-cycle sample waits
        // for the next frame and leaves the holding register full.
        if (accept_s) begin
            hold_d  = to_s16(bus.inSound);
            ready_d = 1'b0;
        end else begin
            hold_d  = hold_q;
        end
    end

    assign bus.inReady   = ready_q;
    assign bus.i2s_bclk  = bclk_q;
    assign bus.i2s_lrck  = lrck_q;
    assign bus.i2s_sdata = sdata_q;
endmodule
